// File: rtl/ni_flit_arb.sv
// Packet-locked round-robin arbiter merging NUM_REQ flit sources onto one NI input.
// Optional stall timeout is compiled in with `define NI_ARB_TIMEOUT_EN.
module ni_flit_arb #(
   parameter int NUM_REQ        = 4,
   parameter int FLIT_W         = 16,
   parameter int PKT_FLITS      = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic [NUM_REQ-1:0]          src_valid,
   input  logic [NUM_REQ*FLIT_W-1:0]   src_flit,
   output logic [NUM_REQ-1:0]          src_ready,
   input  logic                        ni_ready,
   output logic [FLIT_W-1:0]           ni_flit,
   output logic                        ni_enable,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id,
   output logic                        busy,
   output logic                        err_timeout
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int CW = $clog2(PKT_FLITS) + 1;

   typedef enum logic {IDLE, SEND} state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [GW-1:0]   pick, next_ptr;
   logic            pick_vld, g_valid, xfer, tail, timeout_hit;
   logic [FLIT_W-1:0] flit_arr [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_src
         assign flit_arr[gi]  = src_flit[gi*FLIT_W +: FLIT_W];
         assign src_ready[gi] = busy && (grant_q == GW'(gi)) && ni_ready;
      end
      if (NUM_REQ < 2 || PKT_FLITS < 2 || PKT_FLITS > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
         $error("ni_flit_arb: illegal parameter combination");
      end
   endgenerate

   assign busy      = (state_q == SEND);
   assign g_valid   = src_valid[grant_q];
   assign ni_enable = busy && g_valid;
   assign ni_flit   = busy ? flit_arr[grant_q] : '0;
   assign grant_id  = grant_q;
   assign xfer      = busy && g_valid && ni_ready;
   assign tail      = (cnt_q == CW'(PKT_FLITS - 1));
   assign next_ptr  = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

   // Round-robin search: first valid source at or after rr_ptr, wrapping.
   always_comb begin
      int            idx;
      logic [GW-1:0] idx_g;
      idx      = 0;
      idx_g    = '0;
      pick_vld = 1'b0;
      pick     = rr_ptr_q;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx   = (int'(rr_ptr_q) + k) % NUM_REQ;
         idx_g = GW'(idx);
         if (!pick_vld && src_valid[idx_g]) begin
            pick_vld = 1'b1;
            pick     = idx_g;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d = SEND;
               grant_d = pick;
            end
         end
         SEND: begin
            if (xfer) begin
               if (tail) begin
                  state_d  = IDLE;
                  cnt_d    = '0;
                  rr_ptr_d = next_ptr;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (timeout_hit) begin
               state_d  = IDLE;
               cnt_d    = '0;
               rr_ptr_d = next_ptr;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

`ifdef NI_ARB_TIMEOUT_EN
   localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
   logic [SW-1:0] stall_q, stall_d;
   logic          err_q;

   // Only cycles with the granted source silent count; ni_ready stalls keep it at 0.
   always_comb begin
      stall_d     = '0;
      timeout_hit = busy && !g_valid && (stall_q == SW'(TIMEOUT_CYCLES - 1));
      if (busy && !g_valid && !timeout_hit)
         stall_d = stall_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         stall_q <= '0;
         err_q   <= 1'b0;
      end else begin
         stall_q <= stall_d;
         err_q   <= timeout_hit;
      end
   end

   assign err_timeout = err_q;
`else
   assign timeout_hit = 1'b0;
   assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ni_flit_arb.sv
// Directed, table-driven bench for ni_flit_arb (default parameters).
// Timeout checks follow whichever way NI_ARB_TIMEOUT_EN is set for the build.
module tb_ni_flit_arb;

   logic        clk = 1'b0;
   logic        resetn;
   logic [3:0]  src_valid;
   logic [63:0] src_flit;
   logic [3:0]  src_ready;
   logic        ni_ready;
   logic [15:0] ni_flit;
   logic        ni_enable;
   logic [1:0]  grant_id;
   logic        busy;
   logic        err_timeout;

   always #5 clk = ~clk;

   ni_flit_arb dut (
      .clk         (clk),
      .resetn      (resetn),
      .src_valid   (src_valid),
      .src_flit    (src_flit),
      .src_ready   (src_ready),
      .ni_ready    (ni_ready),
      .ni_flit     (ni_flit),
      .ni_enable   (ni_enable),
      .grant_id    (grant_id),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   typedef struct {
      logic        rstn;
      logic [3:0]  valid;
      logic [63:0] flits;
      logic        rdy;
      logic        en;
      logic [15:0] flit;
      logic        bsy;
      logic [1:0]  gid;
      logic [3:0]  srdy;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic logic [63:0] fl(input int src, input logic [15:0] v);
      logic [63:0] r;
      r = 64'(v) << (16 * src);
      return r;
   endfunction

   task automatic add(input logic rs, input logic [3:0] va, input logic [63:0] fls, input logic rd,
                      input logic en, input logic [15:0] f, input logic bz, input logic [1:0] g,
                      input logic [3:0] sr);
      vec_t v;
      v = '{rstn: rs, valid: va, flits: fls, rdy: rd, en: en, flit: f, bsy: bz, gid: g, srdy: sr};
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic en, input logic [15:0] f, input logic bz,
                            input logic [1:0] g, input logic [3:0] sr, input logic er);
      chk({tag, ".ni_enable"}, 64'(ni_enable), 64'(en));
      chk({tag, ".ni_flit"}, 64'(ni_flit), 64'(f));
      chk({tag, ".busy"}, 64'(busy), 64'(bz));
      chk({tag, ".grant_id"}, 64'(grant_id), 64'(g));
      chk({tag, ".src_ready"}, 64'(src_ready), 64'(sr));
      chk({tag, ".err_timeout"}, 64'(err_timeout), 64'(er));
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn    = 1'b0;
      src_valid = '0;
      src_flit  = '0;
      ni_ready  = 1'b1;
      next_cyc();
      next_cyc();
      resetn = 1'b1;
   endtask

   initial begin
      logic [63:0] junk;
      // Single-source packet from source 2
      add(1, 4'b0000, 64'h0,             1, 0, 16'h0,    0, 0, 4'b0000);
      add(1, 4'b0100, fl(2, 16'hA100),   1, 0, 16'h0,    0, 0, 4'b0000);
      add(1, 4'b0100, fl(2, 16'hA100),   1, 1, 16'hA100, 1, 2, 4'b0100);
      add(1, 4'b0100, fl(2, 16'hA201),   1, 1, 16'hA201, 1, 2, 4'b0100);
      add(1, 4'b0100, fl(2, 16'hA302),   1, 1, 16'hA302, 1, 2, 4'b0100);
      add(1, 4'b0100, fl(2, 16'hA4FF),   1, 1, 16'hA4FF, 1, 2, 4'b0100);
      add(1, 4'b0000, 64'h0,             1, 0, 16'h0,    0, 2, 4'b0000);
      // Backpressure on source 1 (rr_ptr=3 wraps to 1); noisy non-granted sources
      junk = 64'hEEEE_DDDD_0000_CCCC | fl(1, 16'hB101);
      add(1, 4'b0010, fl(1, 16'hB000),   1, 0, 16'h0,    0, 2, 4'b0000);
      add(1, 4'b0010, fl(1, 16'hB000),   1, 1, 16'hB000, 1, 1, 4'b0010);
      add(1, 4'b1111, junk,              0, 1, 16'hB101, 1, 1, 4'b0000);
      add(1, 4'b1011, junk ^ 64'h1234_0000_0000_5678, 0, 1, 16'hB101, 1, 1, 4'b0000);
      add(1, 4'b1111, junk,              0, 1, 16'hB101, 1, 1, 4'b0000);
      add(1, 4'b0010, fl(1, 16'hB101),   1, 1, 16'hB101, 1, 1, 4'b0010);
      add(1, 4'b0010, fl(1, 16'hB202),   1, 1, 16'hB202, 1, 1, 4'b0010);
      add(1, 4'b0010, fl(1, 16'hB3FF),   1, 1, 16'hB3FF, 1, 1, 4'b0010);
      add(1, 4'b0000, 64'h0,             1, 0, 16'h0,    0, 1, 4'b0000);
      // Source 0 with a one-cycle valid gap (rr_ptr=2 wraps to 0)
      add(1, 4'b0001, fl(0, 16'hC000),   1, 0, 16'h0,    0, 1, 4'b0000);
      add(1, 4'b0001, fl(0, 16'hC000),   1, 1, 16'hC000, 1, 0, 4'b0001);
      add(1, 4'b0000, fl(0, 16'hC101),   1, 0, 16'hC101, 1, 0, 4'b0001);
      add(1, 4'b0001, fl(0, 16'hC101),   1, 1, 16'hC101, 1, 0, 4'b0001);
      add(1, 4'b0001, fl(0, 16'hC202),   1, 1, 16'hC202, 1, 0, 4'b0001);
      add(1, 4'b0001, fl(0, 16'hC3FF),   1, 1, 16'hC3FF, 1, 0, 4'b0001);
      add(1, 4'b0000, 64'h0,             1, 0, 16'h0,    0, 0, 4'b0000);

      do_reset();
      for (int i = 0; i < vecs.size(); i++) begin
         resetn    = vecs[i].rstn;
         src_valid = vecs[i].valid;
         src_flit  = vecs[i].flits;
         ni_ready  = vecs[i].rdy;
         @(negedge clk);
         $display("row %0d: valid=%b rdy=%b -> en=%b flit=%h busy=%b gid=%0d srdy=%b",
                  i, src_valid, ni_ready, ni_enable, ni_flit, busy, grant_id, src_ready);
         check_out($sformatf("row%0d", i), vecs[i].en, vecs[i].flit, vecs[i].bsy,
                   vecs[i].gid, vecs[i].srdy, 1'b0);
         next_cyc();
      end

      // Contention: all four sources valid, grants 0,1,2,3,0 with one idle cycle between
      do_reset();
      src_valid = 4'b1111;
      src_flit  = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
      ni_ready  = 1'b1;
      for (int p = 0; p < 5; p++) begin
         logic [1:0] g;
         g = 2'(p % 4);
         @(negedge clk);
         check_out($sformatf("cont%0d.idle", p), 1'b0, 16'h0, 1'b0,
                   (p == 0) ? 2'd0 : 2'(g - 2'd1), 4'b0000, 1'b0);
         next_cyc();
         for (int f = 0; f < 4; f++) begin
            @(negedge clk);
            check_out($sformatf("cont%0d.f%0d", p, f), 1'b1, 16'hD000 | 16'(g), 1'b1, g,
                      4'b0001 << g, 1'b0);
            next_cyc();
         end
         $display("contention packet %0d: grant_id=%0d", p, grant_id);
      end

      // Reset mid-packet after two flits of source 1
      do_reset();
      src_valid = 4'b0010;
      src_flit  = fl(1, 16'hF000);
      next_cyc();
      next_cyc();
      next_cyc();
      @(negedge clk);
      chk("midrst.pre.busy", 64'(busy), 64'd1);
      resetn    = 1'b0;
      next_cyc();
      resetn    = 1'b1;
      src_valid = 4'b1010;
      src_flit  = fl(1, 16'hF100) | fl(3, 16'hF300);
      @(negedge clk);
      check_out("midrst.after", 1'b0, 16'h0, 1'b0, 2'd0, 4'b0000, 1'b0);
      next_cyc();
      @(negedge clk);
      check_out("midrst.regrant", 1'b1, 16'hF100, 1'b1, 2'd1, 4'b0010, 1'b0);
      $display("reset mid-packet: regrant to %0d", grant_id);

      // Stall on source 0 after its head flit; source 1 waits
      do_reset();
      src_valid = 4'b0001;
      src_flit  = fl(0, 16'hE000) | fl(1, 16'hE100);
      next_cyc();
      @(negedge clk);
      check_out("stall.head", 1'b1, 16'hE000, 1'b1, 2'd0, 4'b0001, 1'b0);
      next_cyc();
      src_valid = 4'b0010;
`ifdef NI_ARB_TIMEOUT_EN
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         chk($sformatf("tmo.wait%0d.err", k), 64'(err_timeout), 64'd0);
         chk($sformatf("tmo.wait%0d.busy", k), 64'(busy), 64'd1);
         next_cyc();
      end
      @(negedge clk);
      chk("tmo.pulse.err", 64'(err_timeout), 64'd1);
      chk("tmo.pulse.busy", 64'(busy), 64'd0);
      next_cyc();
      @(negedge clk);
      check_out("tmo.regrant", 1'b1, 16'hE100, 1'b1, 2'd1, 4'b0010, 1'b0);
      $display("timeout: err pulse seen, regrant to %0d", grant_id);
`else
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         check_out($sformatf("stall.wait%0d", k), 1'b0, 16'hE000, 1'b1, 2'd0, 4'b0001, 1'b0);
         next_cyc();
      end
      $display("stall: still locked to %0d after 20 cycles", grant_id);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ni_flit_arb.md
NI_FLIT_ARB -- requirements
Module: ni_flit_arb

Interface
- REQ-001: Parameter NUM_REQ, default 4: number of packet sources sharing the NI flit input.
- REQ-002: Parameter FLIT_W, default 16: flit width in bits.
- REQ-003: Parameter PKT_FLITS, default 4: flits per packet (1 head, PKT_FLITS-2 body, 1 tail); legal range 2..16.
- REQ-004: Parameter TIMEOUT_CYCLES, default 16: stall limit used only when the timeout feature is compiled in.
- REQ-005: Port clk, input, 1: single clock; all logic samples on the rising edge.
- REQ-006: Port resetn, input, 1: reset, synchronous and active-low.
- REQ-007: Port src_valid, input, NUM_REQ: source i is presenting a flit.
- REQ-008: Port src_flit, input, NUM_REQ*FLIT_W: flit of source i, at bits [i*FLIT_W +: FLIT_W].
- REQ-009: Port src_ready, output, NUM_REQ: flit of source i is accepted this cycle.
- REQ-010: Port ni_ready, input, 1: NI can accept a flit this cycle.
- REQ-011: Port ni_flit, output, FLIT_W: flit driven to NI i_flit.
- REQ-012: Port ni_enable, output, 1: ni_flit is valid; drives NI enable.
- REQ-013: Port grant_id, output, $clog2(NUM_REQ): index of the currently granted source.
- REQ-014: Port busy, output, 1: high while a packet is locked (state SEND).
- REQ-015: Port err_timeout, output, 1: one-cycle pulse when a packet is aborted.

Function
- REQ-016: The FSM SHALL have two states: IDLE and SEND.
- REQ-017: In IDLE with any src_valid bit high, the arbiter SHALL pick the first requester at or after rr_ptr (round-robin, modulo NUM_REQ), register it into grant_id, and enter SEND on the next edge.
  - Arbitration latency: 1 cycle.
- REQ-018: In IDLE, ni_enable, busy and all src_ready bits SHALL be 0, and ni_flit SHALL be 0.
- REQ-019: In SEND, outputs SHALL be combinational from the granted source g:
  - ni_flit = src_flit[g]
  - ni_enable = src_valid[g]
  - src_ready[g] = ni_ready
  - all other src_ready bits = 0
- REQ-020: A transfer SHALL occur exactly when state is SEND, src_valid[g] is 1 and ni_ready is 1.
- REQ-021: Each transfer SHALL increment a flit counter (width $clog2(PKT_FLITS)+1, starting at 0).
- REQ-022: On the transfer with counter == PKT_FLITS-1 (the tail), the arbiter SHALL:
  - return to IDLE;
  - clear the counter;
  - set rr_ptr = (g+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
- REQ-023: The grant SHALL be packet-locked: no regrant until the tail transfer, regardless of other src_valid bits.
- REQ-024: ni_ready low in SEND SHALL hold the counter and grant; the flit is neither lost nor duplicated.
- REQ-025: src_valid[g] low in SEND SHALL hold state; ni_enable is 0 for that cycle.
- REQ-026: There SHALL be exactly one IDLE cycle between consecutive packets, so back-to-back packet throughput is PKT_FLITS+1 cycles.
- REQ-027: Changes to a non-granted source's src_valid or src_flit SHALL have no effect on outputs.

Reset
- REQ-028: When resetn is 0 at a rising edge, the block SHALL set state=IDLE, counter=0, rr_ptr=0, grant_id=0 and err_timeout=0.
  - All outputs read as in REQ-018 from the following cycle.
- REQ-029: A reset asserted mid-packet SHALL abandon the packet with no further transfers; the first grant after reset goes to the lowest-indexed valid source.

Configuration
- REQ-030: Macro NI_ARB_TIMEOUT_EN, when defined, SHALL enable a stall counter that counts consecutive SEND cycles with src_valid[g]=0.
  - The counter is cleared on any transfer.
  - When it reaches TIMEOUT_CYCLES, the block goes to IDLE, clears the flit counter, sets rr_ptr=(g+1) mod NUM_REQ, and pulses err_timeout for 1 cycle.
- REQ-031: Stalls caused by ni_ready=0 SHALL NOT count toward the timeout.
- REQ-032: Without NI_ARB_TIMEOUT_EN, SEND SHALL wait indefinitely, and err_timeout SHALL be tied to 0 with no stall counter synthesized.

Verification
- REQ-033: Single source: source 2 sends flits 0xA100, 0xA201, 0xA302, 0xA4FF with ni_ready=1 -> grant_id=2; ni_enable high for exactly 4 consecutive cycles carrying those values in order; busy falls after the tail.
- REQ-034: Contention: all 4 sources valid continuously, rr_ptr=0 -> packets granted in order 0,1,2,3,0, each separated by exactly 1 IDLE cycle.
- REQ-035: Backpressure: ni_ready held low during the second flit for 3 cycles -> ni_flit holds the body value and src_ready[g]=0 throughout; exactly 4 transfers in total; no duplicate flits.
- REQ-036: Reset mid-packet: resetn=0 after 2 flits of source 1 -> next cycle busy=0 and ni_enable=0; after release with sources 1 and 3 valid, grant_id=1.
- REQ-037: Timeout (macro defined, TIMEOUT_CYCLES=16): source 0 drops src_valid after the head flit -> err_timeout pulses exactly 16 cycles later and the next grant goes to source 1; with the macro undefined, the block remains in SEND and err_timeout stays 0.
